clock_digit_ctrl: RTL and testbench

CLOCK_DIGIT_CTRL -- requirements
Module: clock_digit_ctrl

---
 rtl/clock_digit_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_clock_digit_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_digit_ctrl.sv
// clock_digit_ctrl: HH:MM:SS digit command sequencer for run and set modes.
// Optional: define SETEXIT_SEC_CLEAR_EN to clear seconds when leaving SET_HOUR.
`timescale 1ns/1ps
module clock_digit_ctrl (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        key_mode,
    input  logic        key_up,
    input  logic        key_down,
    input  logic [23:0] dig_val,
    output logic [5:0]  dig_add,
    output logic [5:0]  dig_sub,
    output logic [5:0]  dig_clear,
    output logic [5:0]  dig_keep,
    output logic [29:0] dig_reset,
    output logic [1:0]  mode
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_SEC  = 2'b01,
        SET_MIN  = 2'b10,
        SET_HOUR = 2'b11
    } mode_e;

    localparam logic [4:0] LD_NONE = 5'b00001;
    localparam logic [4:0] LD_9    = 5'b00010;
    localparam logic [4:0] LD_5    = 5'b00100;
    localparam logic [4:0] LD_3    = 5'b01000;
    localparam logic [4:0] LD_2    = 5'b10000;

    mode_e           mode_q, mode_d;
    logic            busy_q, busy_d;
    logic            pend_q, pend_d;
    logic [5:0]      add_q, add_d;
    logic [5:0]      sub_q, sub_d;
    logic [5:0]      clr_q, clr_d;
    logic [5:0]      keep_q, keep_d;
    logic [5:0][4:0] ld_q, ld_d;
    logic [5:0][3:0] d;
    logic [2:0]      fb, ft;
    logic [1:0]      h_add, h_clr;
    logic            do_mode, do_up, do_down, do_tick;

    assign d  = dig_val;
    // units / tens digit index of the field being set (only used in SET states)
    assign fb = {mode_q - 2'd1, 1'b0};
    assign ft = fb + 3'd1;

    // one accepted event per non-busy cycle: mode > up > down, tick in RUN only
    assign do_mode = !busy_q && key_mode;
    assign do_up   = !busy_q && !key_mode && key_up && (mode_q != RUN);
    assign do_down = !busy_q && !key_mode && !key_up && key_down
                     && (mode_q != RUN);
    assign do_tick = !busy_q && !key_mode && (tick || pend_q)
                     && (mode_q == RUN);
    assign busy_d  = do_mode || do_up || do_down || do_tick;

    // mode state register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) mode_q <= RUN;
        else        mode_q <= mode_d;
    end

    // mode advances one step per accepted key_mode
    always_comb begin
        mode_d = mode_q;
        if (do_mode) begin
            unique case (mode_q)
                RUN:      mode_d = SET_SEC;
                SET_SEC:  mode_d = SET_MIN;
                SET_MIN:  mode_d = SET_HOUR;
                SET_HOUR: mode_d = RUN;
                default:  mode_d = RUN;
            endcase
        end
    end

    // a tick seen while busy waits one slot; SET states throw it away
    always_comb begin
        pend_d = 1'b0;
        if (mode_q == RUN && mode_d == RUN) begin
            if (do_tick) pend_d = tick && pend_q;
            else         pend_d = pend_q || tick;
        end
    end

    // hour field increment with 23 -> 00 wrap
    always_comb begin
        h_add = 2'b00;
        h_clr = 2'b00;
        if (d[5] == 4'd2 && d[4] == 4'd3) begin
            h_clr = 2'b11;
        end else if (d[4] == 4'd9) begin
            h_clr = 2'b01;
            h_add = 2'b10;
        end else begin
            h_add = 2'b01;
        end
    end

    // per-digit command selection for the accepted event
    always_comb begin
        add_d = '0;
        sub_d = '0;
        clr_d = '0;
        ld_d  = {6{LD_NONE}};
        unique case (1'b1)
            do_tick: begin
                if (d[0] != 4'd9) add_d[0] = 1'b1;
                else begin
                    clr_d[0] = 1'b1;
                    if (d[1] != 4'd5) add_d[1] = 1'b1;
                    else begin
                        clr_d[1] = 1'b1;
                        if (d[2] != 4'd9) add_d[2] = 1'b1;
                        else begin
                            clr_d[2] = 1'b1;
                            if (d[3] != 4'd5) add_d[3] = 1'b1;
                            else begin
                                clr_d[3]   = 1'b1;
                                add_d[5:4] = h_add;
                                clr_d[5:4] = h_clr;
                            end
                        end
                    end
                end
            end
            do_up: begin
                if (mode_q == SET_HOUR) begin
                    add_d[5:4] = h_add;
                    clr_d[5:4] = h_clr;
                end else if (d[fb] != 4'd9) begin
                    add_d[fb] = 1'b1;
                end else begin
                    clr_d[fb] = 1'b1;
                    if (d[ft] != 4'd5) add_d[ft] = 1'b1;
                    else               clr_d[ft] = 1'b1;
                end
            end
            do_down: begin
                if (mode_q == SET_HOUR) begin
                    if (d[4] != 4'd0) sub_d[4] = 1'b1;
                    else if (d[5] != 4'd0) begin
                        ld_d[4]  = LD_9;
                        sub_d[5] = 1'b1;
                    end else begin
                        ld_d[4] = LD_3;
                        ld_d[5] = LD_2;
                    end
                end else if (d[fb] != 4'd0) begin
                    sub_d[fb] = 1'b1;
                end else if (d[ft] != 4'd0) begin
                    ld_d[fb]  = LD_9;
                    sub_d[ft] = 1'b1;
                end else begin
                    ld_d[fb] = LD_9;
                    ld_d[ft] = LD_5;
                end
            end
            do_mode: begin
`ifdef SETEXIT_SEC_CLEAR_EN
                if (mode_q == SET_HOUR) clr_d[1:0] = 2'b11;
`endif
            end
            default: begin
            end
        endcase
    end

    // keep marks digits with no other command this cycle
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            keep_d[i] = !(add_d[i] || sub_d[i] || clr_d[i])
                        && (ld_d[i] == LD_NONE);
        end
    end

    // registered one-cycle command strobes and handshake state
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            add_q  <= '0;
            sub_q  <= '0;
            clr_q  <= '0;
            keep_q <= '1;
            ld_q   <= {6{LD_NONE}};
            busy_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            add_q  <= add_d;
            sub_q  <= sub_d;
            clr_q  <= clr_d;
            keep_q <= keep_d;
            ld_q   <= ld_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    assign dig_add   = add_q;
    assign dig_sub   = sub_q;
    assign dig_clear = clr_q;
    assign dig_keep  = keep_q;
    assign dig_reset = ld_q;
    assign mode      = mode_q;

endmodule

// File: tb/tb_clock_digit_ctrl.sv
// tb_clock_digit_ctrl: scoreboard bench for clock_digit_ctrl.
// Reference model keeps time of day in seconds and derives digit commands.
`timescale 1ns/1ps
module tb_clock_digit_ctrl;
    logic        sysclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        key_mode = 1'b0;
    logic        key_up = 1'b0;
    logic        key_down = 1'b0;
    logic [23:0] dig_val = '0;
    logic [5:0]  dig_add, dig_sub, dig_clear, dig_keep;
    logic [29:0] dig_reset;
    logic [1:0]  mode;

    clock_digit_ctrl dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .tick      (tick),
        .key_mode  (key_mode),
        .key_up    (key_up),
        .key_down  (key_down),
        .dig_val   (dig_val),
        .dig_add   (dig_add),
        .dig_sub   (dig_sub),
        .dig_clear (dig_clear),
        .dig_keep  (dig_keep),
        .dig_reset (dig_reset),
        .mode      (mode)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [1:0]  md;
        logic [5:0]  add;
        logic [5:0]  sub;
        logic [5:0]  clr;
        logic [5:0]  keep;
        logic [29:0] rst;
    } rsp_t;

    localparam logic [29:0] IDLE_RST = {6{5'b00001}};

    rsp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_mode = 0;
    int   t_sec = 0;

    function automatic logic [23:0] digits(input int t);
        int h, mi, s;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10),
                4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [4:0] ld_code(input int v);
        case (v)
            9:       return 5'b00010;
            5:       return 5'b00100;
            3:       return 5'b01000;
            2:       return 5'b10000;
            default: return 5'b11111;
        endcase
    endfunction

    // digit-by-digit change from old to new time decides each command
    function automatic rsp_t diff_rsp(input int md, input logic [23:0] o,
                                      input logic [23:0] n);
        rsp_t r;
        int a, b;
        r.md = 2'(md);
        r.add = '0;
        r.sub = '0;
        r.clr = '0;
        r.keep = '1;
        r.rst = IDLE_RST;
        for (int i = 0; i < 6; i++) begin
            a = int'(o[4*i +: 4]);
            b = int'(n[4*i +: 4]);
            if (b == a) begin
            end else if (b == a + 1) r.add[i] = 1'b1;
            else if (b == a - 1) r.sub[i] = 1'b1;
            else if (b == 0) r.clr[i] = 1'b1;
            else r.rst[5*i +: 5] = ld_code(b);
        end
        return r;
    endfunction

    function automatic rsp_t fin_keep(input rsp_t r);
        rsp_t x;
        x = r;
        for (int i = 0; i < 6; i++) begin
            x.keep[i] = !(r.add[i] || r.sub[i] || r.clr[i])
                        && (r.rst[5*i +: 5] == 5'b00001);
        end
        return x;
    endfunction

    // reference model: one accepted event on an idle controller
    task automatic model_event(input bit tk, input bit km,
                               input bit ku, input bit kd);
        int nt, nm, v, w;
        bit push;
        logic [23:0] od;
        rsp_t r;
        nt = t_sec;
        nm = m_mode;
        push = 0;
        od = digits(t_sec);
        if (km) begin
            nm = (m_mode + 1) % 4;
            push = 1;
`ifdef SETEXIT_SEC_CLEAR_EN
            if (m_mode == 3) nt = t_sec - t_sec % 60;
`endif
        end else if (m_mode != 0 && (ku || kd)) begin
            push = 1;
            if (m_mode == 1) begin
                v = t_sec % 60;
                w = ku ? (v + 1) % 60 : (v + 59) % 60;
                nt = t_sec + (w - v);
            end else if (m_mode == 2) begin
                v = (t_sec / 60) % 60;
                w = ku ? (v + 1) % 60 : (v + 59) % 60;
                nt = t_sec + (w - v) * 60;
            end else begin
                v = t_sec / 3600;
                w = ku ? (v + 1) % 24 : (v + 23) % 24;
                nt = t_sec + (w - v) * 3600;
            end
        end else if (m_mode == 0 && tk) begin
            push = 1;
            nt = (t_sec + 1) % 86400;
        end
        if (push) begin
            r = diff_rsp(nm, od, digits(nt));
`ifdef SETEXIT_SEC_CLEAR_EN
            if (km && m_mode == 3) begin
                r.clr[1:0] = 2'b11;
                r.add[1:0] = 2'b00;
                r.sub[1:0] = 2'b00;
                r.rst[9:0] = IDLE_RST[9:0];
            end
`endif
            exp_q.push_back(fin_keep(r));
        end
        m_mode = nm;
        t_sec = nt;
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        t_sec = h * 3600 + mi * 60 + s;
        dig_val = digits(t_sec);
    endtask

    task automatic issue(input bit tk, input bit km,
                         input bit ku, input bit kd);
        tick = tk;
        key_mode = km;
        key_up = ku;
        key_down = kd;
        model_event(tk, km, ku, kd);
        @(posedge sysclk);
        #1;
        tick = 1'b0;
        key_mode = 1'b0;
        key_up = 1'b0;
        key_down = 1'b0;
        dig_val = digits(t_sec);
        @(posedge sysclk);
        #1;
    endtask

    function automatic int pick(input int mx);
        int c;
        c = $urandom_range(0, 2);
        if (c == 0) return 0;
        if (c == 1) return mx;
        return $urandom_range(0, mx);
    endfunction

    // monitor: any strobe or mode change is a response to pop and compare
    initial begin : monitor
        logic [1:0] last;
        rsp_t e, a;
        last = 2'b00;
        forever begin
            @(negedge sysclk);
            if (!rst_n) begin
                last = 2'b00;
                continue;
            end
            a = {mode, dig_add, dig_sub, dig_clear, dig_keep, dig_reset};
            vectors++;
            if (dig_keep != 6'h3f || mode != last) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_cmd act=%h req=none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display({"FAIL cmd_cycle act mode=%0d add=%b sub=%b",
                                  " clr=%b keep=%b rst=%b req mode=%0d add=%b",
                                  " sub=%b clr=%b keep=%b rst=%b"},
                                 a.md, a.add, a.sub, a.clr, a.keep, a.rst,
                                 e.md, e.add, e.sub, e.clr, e.keep, e.rst);
                    end
                end
            end else if ((dig_add | dig_sub | dig_clear) != 6'h00
                         || dig_reset != IDLE_RST) begin
                miscompares++;
                $display("FAIL idle_cycle act=%h req keep-only idle", a);
            end
            last = mode;
        end
    end

    task automatic check_reset_state(input string nm);
        rsp_t a, e;
        a = {mode, dig_add, dig_sub, dig_clear, dig_keep, dig_reset};
        e = {2'b00, 6'h00, 6'h00, 6'h00, 6'h3f, IDLE_RST};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s act=%h req=%h", nm, a, e);
        end
    endtask

    initial begin : stimulus
        int t1;
        #12;
        check_reset_state("reset_state");
        @(negedge sysclk);
        rst_n = 1'b1;
        @(posedge sysclk);
        #1;

        // wrap of the whole day, then a plain seconds carry
        set_time(23, 59, 59);
        issue(1, 0, 0, 0);
        set_time(12, 34, 9);
        issue(1, 0, 0, 0);

        // back-to-back ticks: second one waits and is served after a gap
        set_time(5, 0, 7);
        tick = 1'b1;
        model_event(1, 0, 0, 0);
        t1 = t_sec;
        model_event(1, 0, 0, 0);
        @(posedge sysclk);
        #1;
        dig_val = digits(t1);
        @(posedge sysclk);
        #1;
        tick = 1'b0;
        @(negedge sysclk);
        vectors++;
        if (dig_keep != 6'h3f) begin
            miscompares++;
            $display("FAIL tick_gap act keep=%b req=111111", dig_keep);
        end
        @(posedge sysclk);
        #1;
        dig_val = digits(t_sec);
        @(posedge sysclk);
        #1;

        // key_mode during the tick command cycle is dropped
        tick = 1'b1;
        model_event(1, 0, 0, 0);
        @(posedge sysclk);
        #1;
        tick = 1'b0;
        key_mode = 1'b1;
        dig_val = digits(t_sec);
        @(posedge sysclk);
        #1;
        key_mode = 1'b0;
        @(posedge sysclk);
        #1;

        // set modes: priority, down-wrap loads, ignored tick, dropped key
        issue(0, 1, 0, 0);
        issue(0, 1, 1, 0);
        set_time(7, 0, 30);
        issue(0, 0, 0, 1);
        issue(0, 0, 1, 1);
        issue(0, 1, 0, 0);
        set_time(0, 15, 30);
        issue(0, 0, 0, 1);
        issue(1, 0, 0, 0);
        key_up = 1'b1;
        model_event(0, 0, 1, 0);
        @(posedge sysclk);
        #1;
        dig_val = digits(t_sec);
        @(posedge sysclk);
        #1;
        key_up = 1'b0;
        @(posedge sysclk);
        #1;
        set_time(20, 15, 31);
        issue(0, 0, 0, 1);
        issue(0, 1, 0, 0);

        // reset in the middle of a command cycle
        issue(0, 1, 0, 0);
        issue(0, 1, 0, 0);
        key_up = 1'b1;
        @(posedge sysclk);
        #1;
        key_up = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_mid_cmd");
        m_mode = 0;
        @(negedge sysclk);
        #2;
        rst_n = 1'b1;
        @(posedge sysclk);
        #1;
        @(posedge sysclk);
        #1;

        // randomized traffic with boundary-biased times
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0)
                set_time(pick(23), pick(59), pick(59));
            issue($urandom_range(0, 1) == 1,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge sysclk);
                #1;
            end
        end

        repeat (4) @(posedge sysclk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_cmds act pending=%0d req=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
